coin_credit_fsm: RTL and testbench

COIN_CREDIT_FSM -- requirements
Module: coin_credit_fsm

---
 rtl/vend_pkg.sv | 22 ++
 rtl/coin_credit_fsm_if.sv | 25 ++
 rtl/coin_credit_fsm_coin_edge.sv | 21 ++
 rtl/coin_credit_fsm.sv | 82 ++++++++
 tb/tb_coin_credit_fsm.sv | 116 +++++++++++
 5 files changed

// File: rtl/vend_pkg.sv
// Shared types for the coin credit machine: FSM states, coin codes and coin values.
package vend_pkg;

  typedef enum logic [1:0] {COLLECT, DISPENSE, REFUND} state_t;

  typedef logic [1:0] coin_t;

  localparam coin_t NONE     = 2'b00;
  localparam coin_t FARTHING = 2'b01;
  localparam coin_t HAPENNY  = 2'b10;
  localparam coin_t PENNY    = 2'b11;

  function automatic logic [2:0] coin_value(input coin_t c);
    case (c)
      FARTHING: coin_value = 3'd1;
      HAPENNY:  coin_value = 3'd2;
      PENNY:    coin_value = 3'd4;
      default:  coin_value = 3'd0;
    endcase
  endfunction

endpackage

// File: rtl/coin_credit_fsm_if.sv
// Coin input, cancel request, change-return handshake and status outputs.
interface coin_credit_fsm_if
  import vend_pkg::*;
#(
  parameter int CREDIT_W = 5
);
  coin_t               coin;
  logic                cancel;
  logic                ret_ready;
  logic [CREDIT_W-1:0] credit;
  logic                vend;
  logic                ret_valid;
  coin_t               ret_coin;
  logic                coin_rej;

  modport master (
    output coin, cancel, ret_ready,
    input  credit, vend, ret_valid, ret_coin, coin_rej
  );

  modport slave (
    input  coin, cancel, ret_ready,
    output credit, vend, ret_valid, ret_coin, coin_rej
  );
endinterface

// File: rtl/coin_credit_fsm_coin_edge.sv
// Insertion detector: a non-zero code following a sampled 00 is one event.
module coin_edge
  import vend_pkg::*;
(
  input  logic  clk,
  input  logic  reset,
  input  coin_t coin,
  output logic  ins_evt,
  output coin_t code
);
  coin_t prev;

  // Reset parks prev at PENNY so a coin held through reset needs a release first.
  always_ff @(posedge clk) begin
    if (reset) prev <= PENNY;
    else       prev <= coin;
  end

  assign ins_evt = (coin != NONE) && (prev == NONE);
  assign code    = coin;
endmodule

// File: rtl/coin_credit_fsm.sv
// Coin credit FSM: collects coins, vends at PRICE, returns change one coin at a time.
module coin_credit_fsm
  import vend_pkg::*;
#(
  parameter int PRICE    = 6,
  parameter int CREDIT_W = 5
)(
  input logic               clk,
  input logic               reset,
  coin_credit_fsm_if.slave  bus
);
  localparam logic [CREDIT_W-1:0] PRICE_C = CREDIT_W'(PRICE);

  state_t              state, state_n;
  logic [CREDIT_W-1:0] credit, credit_n, sum, remain, coin_val;
  logic                coin_rej;
  logic                ins_evt;
  coin_t               code, change;

  coin_edge u_edge (
    .clk     (clk),
    .reset   (reset),
    .coin    (bus.coin),
    .ins_evt (ins_evt),
    .code    (code)
  );

  assign coin_val = CREDIT_W'(coin_value(code));

  // Largest coin not exceeding the held credit.
  always_comb begin
    change = FARTHING;
    if      (credit >= CREDIT_W'(4)) change = PENNY;
    else if (credit >= CREDIT_W'(2)) change = HAPENNY;
  end

  always_comb begin
    state_n       = state;
    credit_n      = credit;
    sum           = credit + (ins_evt ? coin_val : '0);
    remain        = credit - PRICE_C;
    bus.vend      = 1'b0;
    bus.ret_valid = 1'b0;
    bus.ret_coin  = NONE;
    case (state)
      COLLECT: begin
        credit_n = sum;
        if (bus.cancel && sum != '0) state_n = REFUND;
        else if (sum >= PRICE_C)     state_n = DISPENSE;
      end
      DISPENSE: begin
        bus.vend = 1'b1;
        credit_n = remain;
        state_n  = (remain != '0) ? REFUND : COLLECT;
      end
      REFUND: begin
        bus.ret_valid = 1'b1;
        bus.ret_coin  = change;
        if (bus.ret_ready) begin
          credit_n = credit - CREDIT_W'(coin_value(change));
          if (credit_n == '0) state_n = COLLECT;
        end
      end
      default: state_n = COLLECT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= COLLECT;
      credit   <= '0;
      coin_rej <= 1'b0;
    end else begin
      state    <= state_n;
      credit   <= credit_n;
      coin_rej <= ins_evt && (state != COLLECT);
    end
  end

  assign bus.credit   = credit;
  assign bus.coin_rej = coin_rej;
endmodule

// File: tb/tb_coin_credit_fsm.sv
// Directed bench for coin_credit_fsm with PRICE=6, hand-computed expectations.
module tb_coin_credit_fsm;
  logic clk = 1'b0;
  logic reset;
  int   n_tot = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  coin_credit_fsm_if #(.CREDIT_W(5)) bus ();

  coin_credit_fsm #(.PRICE(6), .CREDIT_W(5)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  task automatic chk(input string tag, input int obs, input int exp);
    n_tot++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask

  task automatic outs(input string tag, input int cr, input int vd,
                      input int rv, input int rc, input int rj);
    chk({tag, ".credit"},    int'(bus.credit),    cr);
    chk({tag, ".vend"},      int'(bus.vend),      vd);
    chk({tag, ".ret_valid"}, int'(bus.ret_valid), rv);
    chk({tag, ".ret_coin"},  int'(bus.ret_coin),  rc);
    chk({tag, ".coin_rej"},  int'(bus.coin_rej),  rj);
  endtask

  // Drive inputs, take one rising edge, settle 1 time unit after it.
  task automatic cyc(input logic [1:0] c, input logic cn, input logic rr);
    bus.coin      = c;
    bus.cancel    = cn;
    bus.ret_ready = rr;
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset         = 1'b1;
    bus.coin      = 2'b00;
    bus.cancel    = 1'b0;
    bus.ret_ready = 1'b0;
    cyc(0, 0, 0); cyc(0, 0, 0);
    outs("rst", 0, 0, 0, 0, 0);
    reset = 1'b0;
    cyc(0, 0, 0); outs("idle", 0, 0, 0, 0, 0);
    cyc(0, 1, 0); outs("cancel0", 0, 0, 0, 0, 0);

    // exact price: 4 + 2
    cyc(3, 0, 0); outs("t1a", 4, 0, 0, 0, 0);
    cyc(0, 0, 0);
    cyc(2, 0, 0); outs("t1b", 6, 1, 0, 0, 0);
    cyc(0, 0, 0); outs("t1c", 0, 0, 0, 0, 0);
    cyc(0, 0, 0); outs("t1d", 0, 0, 0, 0, 0);

    // overpay 8, change 2 held while not ready
    cyc(3, 0, 0); outs("t2a", 4, 0, 0, 0, 0);
    cyc(0, 0, 0);
    cyc(3, 0, 0); outs("t2b", 8, 1, 0, 0, 0);
    cyc(0, 0, 0); outs("t2c", 2, 0, 1, 2, 0);
    cyc(0, 0, 0); outs("t2h1", 2, 0, 1, 2, 0);
    cyc(0, 0, 0); outs("t2h2", 2, 0, 1, 2, 0);
    cyc(0, 0, 1); outs("t2d", 0, 0, 0, 0, 0);

    // three farthings then cancel
    cyc(1, 0, 0); outs("t3i1", 1, 0, 0, 0, 0);
    cyc(0, 0, 0);
    cyc(1, 0, 0); outs("t3i2", 2, 0, 0, 0, 0);
    cyc(0, 0, 0);
    cyc(1, 0, 0); outs("t3i3", 3, 0, 0, 0, 0);
    cyc(0, 0, 0);
    cyc(0, 1, 0); outs("t3a", 3, 0, 1, 2, 0);
    cyc(0, 0, 1); outs("t3b", 1, 0, 1, 1, 0);
    cyc(0, 0, 1); outs("t3c", 0, 0, 0, 0, 0);

    // held penny counts once; insertion during refund is rejected
    cyc(3, 0, 0); outs("t4h1", 4, 0, 0, 0, 0);
    cyc(3, 0, 0); cyc(3, 0, 0); cyc(3, 0, 0);
    cyc(3, 0, 0); outs("t4h5", 4, 0, 0, 0, 0);
    cyc(0, 0, 0); outs("t4rel", 4, 0, 0, 0, 0);
    cyc(0, 1, 0); outs("t4r", 4, 0, 1, 3, 0);
    cyc(1, 0, 0); outs("t4rej", 4, 0, 1, 3, 1);
    cyc(0, 0, 0); outs("t4rej2", 4, 0, 1, 3, 0);
    cyc(0, 0, 1); outs("t4d", 0, 0, 0, 0, 0);

    // insertion reaching price with cancel in the same cycle: refund, no vend
    cyc(3, 0, 0); outs("t5i", 4, 0, 0, 0, 0);
    cyc(0, 0, 0);
    cyc(2, 1, 0); outs("t5a", 6, 0, 1, 3, 0);
    cyc(0, 0, 1); outs("t5b", 2, 0, 1, 2, 0);
    cyc(0, 0, 1); outs("t5c", 0, 0, 0, 0, 0);

    // reset during refund with a penny held
    cyc(3, 0, 0); outs("t6i", 4, 0, 0, 0, 0);
    cyc(0, 0, 0);
    cyc(0, 1, 0); outs("t6r", 4, 0, 1, 3, 0);
    cyc(3, 0, 0); outs("t6rej", 4, 0, 1, 3, 1);
    reset = 1'b1;
    cyc(3, 0, 0); outs("t6rst", 0, 0, 0, 0, 0);
    reset = 1'b0;
    cyc(3, 0, 0); outs("t6held1", 0, 0, 0, 0, 0);
    cyc(3, 0, 0); outs("t6held2", 0, 0, 0, 0, 0);
    cyc(0, 0, 0); outs("t6rel", 0, 0, 0, 0, 0);
    cyc(3, 0, 0); outs("t6new", 4, 0, 0, 0, 0);
    cyc(0, 0, 0);

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end
endmodule
